// File: rtl/rv_pkg.sv
// Shared types for the RV64 pipeline: ALU opcodes, memory op kinds, EX state
// and the EX/MEM boundary bundle.
package rv_pkg;
  localparam int XLEN   = 64;
  localparam int ADDR_W = 48;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [3:0] {
    MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU,
    SB, SH, SW, SD, FLW, FLD, FSW, FSD
  } mem_type_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} ex_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] mem_addr;
    mem_type_t         mem_type;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   result;
    logic [4:0]        rd;
    logic              we_rd;
    logic              reg_type;
  } ex_out_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/stage3_div.sv
// Iterative restoring divider on operand magnitudes; one quotient bit per edge,
// the last step and the sign fix-up are combinational on the completing edge.
module stage3_div
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            n_reset,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            word_i,
  input  logic            is_rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            neg_q_q, neg_r_q, word_q, is_rem_q;
  logic [5:0]      cnt_q;

  logic            sa, sb;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic [XLEN:0]   sh, diff;
  logic [XLEN-1:0] rem_n, quo_n, q_s, r_s, res;

  always_comb begin
    sa    = signed_i & (word_i ? dividend_i[31] : dividend_i[63]);
    sb    = signed_i & (word_i ? divisor_i[31]  : divisor_i[63]);
    a_ext = word_i ? {{32{sa}}, dividend_i[31:0]} : dividend_i;
    b_ext = word_i ? {{32{sb}}, divisor_i[31:0]}  : divisor_i;
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    // One restoring step; the partial remainder always fits 64 bits.
    sh    = {rem_q, quo_q[63]};
    diff  = sh - {1'b0, dvs_q};
    rem_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_n = {quo_q[62:0], ~diff[XLEN]};
    q_s   = neg_q_q ? -quo_n : quo_n;
    r_s   = neg_r_q ? -rem_n : rem_n;
    res   = is_rem_q ? r_s : q_s;
  end

  assign done_o   = (cnt_q == 6'd0);
  assign result_o = word_q ? sext32(res[31:0]) : res;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rem_q <= '0; quo_q <= '0; dvs_q <= '0; cnt_q <= '0;
      neg_q_q <= 1'b0; neg_r_q <= 1'b0; word_q <= 1'b0; is_rem_q <= 1'b0;
    end else if (start_i) begin
      rem_q    <= '0;
      quo_q    <= word_i ? {a_mag[31:0], 32'b0} : a_mag;
      dvs_q    <= word_i ? {32'b0, b_mag[31:0]} : b_mag;
      cnt_q    <= word_i ? 6'd31 : 6'd63;
      neg_q_q  <= sa ^ sb;
      neg_r_q  <= sa;
      word_q   <= word_i;
      is_rem_q <= is_rem_i;
    end else if (cnt_q != 6'd0) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - 6'd1;
    end
  end
endmodule

// File: rtl/stage3.sv
// Execute stage: single-cycle ALU and address generation, multi-cycle MUL/DIV,
// registered EX/MEM outputs.
module stage3
  import rv_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              valid_id,
  input  logic [4:0]        alu_op_id,
  input  logic              word_op_id,
  input  logic [XLEN-1:0]   op_a_id,
  input  logic [XLEN-1:0]   op_b_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic              use_imm_id,
  input  logic [3:0]        type_op_id,
  input  logic [4:0]        rd_id,
  input  logic              we_rd_id,
  input  logic              reg_type_id,
  input  logic              flush_ex,
  output logic              busy_ex,
  output logic [ADDR_W-1:0] mem_addr_ex,
  output logic [3:0]        type_op_mem,
  output logic [XLEN-1:0]   store_data_ex,
  output logic [XLEN-1:0]   op_ex,
  output logic [4:0]        rd_ex,
  output logic              we_rd_ex,
  output logic              reg_type_ex
);
  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);

  ex_state_t       state_q;
  logic [5:0]      cnt_q;
  ex_out_t         out_q, pend_q, side_q, fresh, side;
  logic            pend_vld_q;
  alu_op_t         op, mop_q;
  logic            mword_q;
  logic [XLEN-1:0] ma_q, mb_q;

  logic [XLEN-1:0]   src_b, a_zx, a_sx, alu, sp_res, mul_res, div_res, mc_res;
  logic [5:0]        shamt;
  logic [ADDR_W-1:0] ea;
  logic [127:0]      prod;
  logic is_mul, is_div, div_signed, div_rem, b_zero, ovf, long_div;
  logic accept, retire, div_done, msa, msb;

  assign op      = alu_op_t'(alu_op_id);
  assign busy_ex = (state_q != S_IDLE) && (cnt_q != 6'd0);
  assign accept  = valid_id && !busy_ex && !flush_ex;
  assign retire  = (state_q == S_MUL && cnt_q == 6'd0) || (state_q == S_DIV && div_done);

  always_comb begin
    src_b      = use_imm_id ? imm_id : op_b_id;
    shamt      = word_op_id ? {1'b0, src_b[4:0]} : src_b[5:0];
    a_zx       = word_op_id ? {32'b0, op_a_id[31:0]} : op_a_id;
    a_sx       = word_op_id ? sext32(op_a_id[31:0]) : op_a_id;
    ea         = op_a_id[ADDR_W-1:0] + imm_id[ADDR_W-1:0];
    is_mul     = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    is_div     = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    div_signed = (op == ALU_DIV) || (op == ALU_REM);
    div_rem    = (op == ALU_REM) || (op == ALU_REMU);
    b_zero     = word_op_id ? (src_b[31:0] == 32'd0) : (src_b == '0);
    ovf        = div_signed && (word_op_id
                 ? (op_a_id[31:0] == 32'h8000_0000 && &src_b[31:0])
                 : (op_a_id == {1'b1, {(XLEN-1){1'b0}}} && &src_b));
    long_div   = is_div && !b_zero && !ovf;
    // Divide-by-zero and signed overflow resolve here without iterating.
    sp_res     = div_rem ? (b_zero ? a_sx : '0) : (b_zero ? '1 : a_sx);
    case (op)
      ALU_ADD:  alu = op_a_id + src_b;
      ALU_SUB:  alu = op_a_id - src_b;
      ALU_SLL:  alu = op_a_id << shamt;
      ALU_SLT:  alu = {63'd0, $signed(op_a_id) < $signed(src_b)};
      ALU_SLTU: alu = {63'd0, op_a_id < src_b};
      ALU_XOR:  alu = op_a_id ^ src_b;
      ALU_SRL:  alu = a_zx >> shamt;
      ALU_SRA:  alu = $signed(a_sx) >>> shamt;
      ALU_OR:   alu = op_a_id | src_b;
      ALU_AND:  alu = op_a_id & src_b;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu = sp_res;
      default:  alu = '0;
    endcase
    if (word_op_id) alu = sext32(alu[31:0]);

    fresh            = '0;
    fresh.mem_addr   = ea;
    fresh.mem_type   = mem_type_t'(type_op_id);
    fresh.store_data = op_b_id;
    fresh.result     = alu;
    fresh.rd         = rd_id;
    fresh.we_rd      = we_rd_id;
    fresh.reg_type   = reg_type_id;
    side             = fresh;
    side.mem_addr    = '0;
    side.store_data  = '0;
    side.result      = '0;
  end

  // Sign-extending both operands to 128 bits yields every signedness mix.
  always_comb begin
    msa     = (mop_q == ALU_MULH) || (mop_q == ALU_MULHSU);
    msb     = (mop_q == ALU_MULH);
    prod    = {{64{msa & ma_q[63]}}, ma_q} * {{64{msb & mb_q[63]}}, mb_q};
    mul_res = (mop_q == ALU_MUL) ? (mword_q ? sext32(prod[31:0]) : prod[63:0])
                                 : prod[127:64];
    mc_res  = (state_q == S_MUL) ? mul_res : div_res;
  end

  stage3_div u_div (
    .clk        (clk),
    .n_reset    (n_reset),
    .start_i    (accept && long_div),
    .signed_i   (div_signed),
    .word_i     (word_op_id),
    .is_rem_i   (div_rem),
    .dividend_i (op_a_id),
    .divisor_i  (src_b),
    .done_o     (div_done),
    .result_o   (div_res)
  );

  // A single-cycle op accepted while the output slot is taken waits one edge in pend_q.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE; cnt_q <= '0; out_q <= '0; pend_q <= '0; pend_vld_q <= 1'b0;
      side_q <= '0; mop_q <= ALU_ADD; mword_q <= 1'b0; ma_q <= '0; mb_q <= '0;
    end else begin
      out_q <= '0;
      if (flush_ex) begin
        state_q    <= S_IDLE;
        cnt_q      <= '0;
        pend_vld_q <= 1'b0;
      end else begin
        pend_vld_q <= 1'b0;
        if (pend_vld_q) out_q <= pend_q;
        if (retire) begin
          out_q        <= side_q;
          out_q.result <= mc_res;
          state_q      <= S_IDLE;
        end else if (state_q != S_IDLE) begin
          cnt_q <= cnt_q - 6'd1;
        end
        if (accept) begin
          if (is_mul || long_div) begin
            state_q <= is_mul ? S_MUL : S_DIV;
            cnt_q   <= is_mul ? MUL_LAST : (word_op_id ? 6'd31 : 6'd63);
            side_q  <= side;
            mop_q   <= op;
            mword_q <= word_op_id;
            ma_q    <= op_a_id;
            mb_q    <= src_b;
          end else if (retire || pend_vld_q) begin
            pend_q     <= fresh;
            pend_vld_q <= 1'b1;
          end else begin
            out_q <= fresh;
          end
        end
      end
    end
  end

  assign mem_addr_ex   = out_q.mem_addr;
  assign type_op_mem   = out_q.mem_type;
  assign store_data_ex = out_q.store_data;
  assign op_ex         = out_q.result;
  assign rd_ex         = out_q.rd;
  assign we_rd_ex      = out_q.we_rd;
  assign reg_type_ex   = out_q.reg_type;
endmodule

// File: doc/stage3.md
Name: stage3

Overview:
- Execute stage of the RV64IMFD five-stage pipeline. Sits between decode (stage2) and memory (stage4).
- Performs RV64I integer ALU ops, RV64M multiply/divide, and load/store effective-address generation.
- Registers results into the EX/MEM boundary signals that stage4 consumes.
- FP arithmetic is out of scope. reg_type passes through so FLD/FSD/FP writebacks reach later stages.

Parameters:
- XLEN, 64, datapath width.
- ADDR_W, 48, effective-address width driven to stage4.
- MUL_CYCLES, 3, fixed multiply latency in cycles; minimum 1.

Ports:
- clk  in  1  clock.
- n_reset  in  1  asynchronous active-low reset.
- valid_id  in  1  decode presents a valid op.
- alu_op_id  in  5  alu_op_t.
- word_op_id  in  1  *W variant: 32-bit op, result sign-extended.
- op_a_id  in  64  rs1 value.
- op_b_id  in  64  rs2 value.
- imm_id  in  64  sign-extended immediate.
- use_imm_id  in  1  second ALU operand is imm_id instead of op_b_id.
- type_op_id  in  4  mem_type_t; MEM_NONE for non-memory ops.
- rd_id  in  5  destination register.
- we_rd_id  in  1  destination write enable.
- reg_type_id  in  1  0 = integer file, 1 = FP file.
- flush_ex  in  1  kill the in-flight op.
- busy_ex  out  1  stall to decode; decode holds its inputs while high.
- mem_addr_ex  out  48  effective address (op_a + imm)[47:0].
- type_op_mem  out  4  memory op to stage4.
- store_data_ex  out  64  op_b_id, registered.
- op_ex  out  64  ALU/MUL/DIV result.
- rd_ex  out  5  destination register.
- we_rd_ex  out  1  destination write enable.
- reg_type_ex  out  1  register-file select.

Behaviour:
- Reset (n_reset low, asynchronous): all outputs 0, type_op_mem = MEM_NONE, FSM = IDLE, divider registers and counter cleared. Reset in mid-divide or mid-multiply abandons the op; no partial result is emitted.
- Accept: an op is accepted on any edge where valid_id = 1 and busy_ex = 0.
- Bubble: on any edge where nothing completes, outputs take bubble values (we_rd_ex = 0, type_op_mem = MEM_NONE); other outputs are don't-care but driven to 0.
- Single-cycle ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; memory address generation):
  - Result is registered on the accept edge, so latency is 1.
  - Shift amount is op_b[5:0], or op_b[4:0] when word_op.
  - Word ops compute on bits [31:0] and sign-extend bit 31 into [63:32].
- FSM states: IDLE, MUL, DIV.
  - IDLE to MUL: on accepting MUL, MULH, MULHSU or MULHU. Counter loads MUL_CYCLES-1.
  - IDLE to DIV: on accepting DIV, DIVU, REM or REMU that is not a special case. Counter loads 63, or 31 when word_op.
  - MUL/DIV to IDLE: on the edge where counter = 0. That edge writes the result to the outputs.
  - Counter decrements on every other edge in MUL/DIV.
- busy_ex = (state != IDLE) && !(counter == 0).
  - A new op may therefore be accepted on the same edge the multicycle result retires.
  - Multiply latency is MUL_CYCLES. 64-bit divide latency is 64; word divide latency is 32.
  - Outputs show bubbles while the op is in flight.
- Multiply:
  - Full 128-bit product; signedness per op.
  - MUL returns the low 64 bits; MULH/MULHSU/MULHU return the high 64 bits.
  - MULW returns low 32 bits, sign-extended.
- Divide: restoring algorithm, 1 quotient bit per cycle on operand magnitudes; signs are fixed up at the final edge.
- Divide special cases resolve in 1 cycle, with no DIV state entered:
  - Divisor zero: quotient = all ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0.
  - Word forms apply both rules on 32 bits, then sign-extend.
- Sideband capture: rd, we_rd, reg_type and type_op for multicycle ops are captured at accept and presented with the result.
- flush_ex:
  - Forces a bubble on the next edge and returns the FSM to IDLE, cancelling any in-flight op.
  - Flush has priority over accept and over completion.
  - With flush_ex and valid_id high together, the op is not accepted and busy_ex is 0 for the following cycle.
- Out of scope: no forwarding or hazard detection in this block.

Decomposition:
- Package rv_pkg holds:
  - alu_op_t enum (5 bits; ADD..AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - mem_type_t enum (4 bits; MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, FLW, FLD, FSW, FSD).
  - ex_state_t.
  - XLEN and ADDR_W constants.
- Sub-module stage3_div owns the iterative divider. Interface: start, signed, word, is_rem, operands, done, result.
- Multiplier and ALU stay inline.

Test Plan:
- ADD: op_a = 5, imm = -3, use_imm = 1 -> op_ex = 2 one edge later, we_rd_ex = 1, busy_ex never high.
- ADDW: op_a = 0x7FFF_FFFF, op_b = 1 -> op_ex = 0xFFFF_FFFF_8000_0000.
- SD: op_a = 0x1_0000_0000_1000, imm = 8, op_b = 0xDEAD -> mem_addr_ex = 0x0000_0000_1008, store_data_ex = 0xDEAD, type_op_mem = SD, we_rd_ex = 0.
- MULHU: 0xFFFF_FFFF_FFFF_FFFF × 2 (MUL_CYCLES = 3) -> busy_ex high 2 cycles, op_ex = 1 on the 3rd edge; a following ADD presented throughout is accepted on that same edge.
- DIV: -7 / 2 -> busy 63 cycles, op_ex = -3 on edge 64; REM gives -1; DIVW gives 32-cycle latency; DIVU by 0 gives all ones in 1 cycle; DIV of 0x8000_0000_0000_0000 by -1 gives 0x8000_0000_0000_0000 in 1 cycle.
- flush_ex asserted at cycle 10 of a DIV -> bubble output, busy_ex low next cycle, no result ever emitted. n_reset pulsed mid-MUL -> outputs 0 immediately.
